// File: rtl/btn_irq_servicer_pkg.sv
// Shared definitions for the push-button interrupt servicer.
//   - PIO word addresses (data / irq_mask / edge_capture)
//   - write-data pattern that clears every edge_capture bit
//   - servicer FSM state encoding
package btn_irq_servicer_pkg;

    localparam logic [1:0]  ADDR_DATA = 2'd0;
    localparam logic [1:0]  ADDR_MASK = 2'd2;
    localparam logic [1:0]  ADDR_EDGE = 2'd3;

    localparam logic [31:0] CLR_ALL   = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ST_INIT_MASK,
        ST_IDLE,
        ST_WR_MASK,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_CLR,
        ST_EMIT,
        ST_HOLDOFF
    } svc_state_e;

endpackage

// File: rtl/btn_irq_servicer_timer.sv
// Debounce hold-off down-counter.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   load_i  : restart a hold-off period
//   count_i : decrement while the hold-off is in progress
//   done_o  : high once HOLDOFF_CYCLES counting cycles have elapsed since load
module btn_holdoff_timer #(
    parameter int unsigned HOLDOFF_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    // Loading N-1 and finishing at zero gives exactly N cycles in the hold-off state.
    localparam int unsigned LOAD_VAL = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
    localparam int unsigned TW       = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TW'(LOAD_VAL);
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/btn_irq_servicer.sv
// Hardware interrupt servicer for the push-button PIO. Sole Avalon-MM master
// of the PIO: programs irq_mask after reset, services irq by reading and
// clearing edge_capture, and hands the captured set downstream as a
// valid/ready event followed by a debounce hold-off.
//   clk, reset_n           : clock, asynchronous active-low reset
//   en                     : service enable (checked only in IDLE)
//   cfg_mask, cfg_mask_wr  : request an irq_mask rewrite (last pulse wins)
//   irq                    : PIO interrupt
//   avm_*                  : registered Avalon-MM master to the PIO
//   evt_valid/ready/buttons: downstream event handshake
//   evt_count              : accepted events since reset, wrapping
//   busy                   : FSM outside IDLE
module btn_irq_servicer
    import btn_irq_servicer_pkg::*;
#(
    parameter int unsigned       N_BTN          = 2,
    parameter logic [N_BTN-1:0]  MASK_INIT      = '1,
    parameter int unsigned       HOLDOFF_CYCLES = 50000,
    parameter int unsigned       CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [N_BTN-1:0] cfg_mask,
    input  logic             cfg_mask_wr,
    input  logic             irq,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] evt_buttons,
    output logic [CNT_W-1:0] evt_count,
    output logic             busy
);

    svc_state_e       state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic             cs_q, cs_d;
    logic             wn_q, wn_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [N_BTN-1:0] cap_q, cap_d;
    logic             valid_q, valid_d;
    logic [N_BTN-1:0] buttons_q, buttons_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic [N_BTN-1:0] lat_q, lat_d;
    logic             hold_load, hold_done;

    btn_holdoff_timer #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_timer (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .load_i (hold_load),
        .count_i(state_q == ST_HOLDOFF),
        .done_o (hold_done)
    );

    // Bus outputs are computed for the state being entered, so each bus cycle
    // coincides with its state. INIT_MASK is the exception: its outputs are
    // still at reset values, so its write is presented in the following cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = ADDR_DATA;
        cs_d      = 1'b0;
        wn_d      = 1'b1;
        wdata_d   = wdata_q;
        cap_d     = cap_q;
        count_d   = count_q;
        pend_d    = pend_q;
        lat_d     = lat_q;
        hold_load = 1'b0;

        case (state_q)
            ST_INIT_MASK: begin
                state_d = ST_IDLE;
                addr_d  = ADDR_MASK;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                wdata_d = 32'(MASK_INIT);
            end
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_WR_MASK;
                    addr_d  = ADDR_MASK;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                    wdata_d = 32'(lat_q);
                    pend_d  = 1'b0;
                end else if (en && irq) begin
                    state_d = ST_RD_ADDR;
                    addr_d  = ADDR_EDGE;
                end
            end
            ST_WR_MASK: state_d = ST_IDLE;
            ST_RD_ADDR: begin
                state_d = ST_RD_WAIT;
                addr_d  = ADDR_EDGE;
            end
            ST_RD_WAIT: begin
                state_d = ST_RD_CAP;
                addr_d  = ADDR_EDGE;
            end
            ST_RD_CAP: begin
                cap_d   = avm_readdata[N_BTN-1:0];
                state_d = ST_CLR;
                addr_d  = ADDR_EDGE;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                wdata_d = CLR_ALL;
            end
            ST_CLR: state_d = (cap_q == '0) ? ST_IDLE : ST_EMIT;
            ST_EMIT: begin
                if (valid_q && evt_ready) begin
                    count_d   = count_q + CNT_W'(1);
                    hold_load = 1'b1;
                    state_d   = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: if (hold_done) state_d = ST_IDLE;
            default:    state_d = ST_INIT_MASK;
        endcase

        // A request arriving in the same cycle as a mask write stays pending,
        // so the newest value is always written eventually.
        if (cfg_mask_wr) begin
            lat_d  = cfg_mask;
            pend_d = 1'b1;
        end

        valid_d   = (state_d == ST_EMIT);
        buttons_d = valid_d ? cap_d : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT_MASK;
            addr_q    <= ADDR_DATA;
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            wdata_q   <= '0;
            cap_q     <= '0;
            valid_q   <= 1'b0;
            buttons_q <= '0;
            count_q   <= '0;
            pend_q    <= 1'b0;
            lat_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            wdata_q   <= wdata_d;
            cap_q     <= cap_d;
            valid_q   <= valid_d;
            buttons_q <= buttons_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            lat_q     <= lat_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wdata_q;
    assign evt_valid      = valid_q;
    assign evt_buttons    = buttons_q;
    assign evt_count      = count_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_btn_irq_servicer.sv
// Directed bench for btn_irq_servicer with a behavioural 2-button PIO.
module tb_btn_irq_servicer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [1:0]  cfg_mask;
    logic        cfg_mask_wr;
    logic        irq;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_buttons;
    logic [15:0] evt_count;
    logic        busy;

    always #5 clk = ~clk;

    btn_irq_servicer #(
        .N_BTN         (2),
        .MASK_INIT     (2'b11),
        .HOLDOFF_CYCLES(8),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .cfg_mask      (cfg_mask),
        .cfg_mask_wr   (cfg_mask_wr),
        .irq           (irq),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_buttons   (evt_buttons),
        .evt_count     (evt_count),
        .busy          (busy)
    );

    // PIO model: registered readdata, irq_mask at 2, edge_capture at 3
    // (write-1-to-clear). inj sets capture bits; force_irq fakes a spurious irq.
    logic [1:0]  edge_cap  = 2'b00;
    logic [1:0]  pio_mask  = 2'b00;
    logic [1:0]  inj       = 2'b00;
    logic        force_irq = 1'b0;
    logic [1:0]  clr_bits;
    logic        rd_prev   = 1'b0;

    // Access log: kind 0 = write, 1 = start of a read of address 3.
    int          ev_kind [64];
    logic [1:0]  ev_addr [64];
    logic [31:0] ev_data [64];
    int          ev_n = 0;

    assign irq = (|(edge_cap & pio_mask)) | force_irq;

    always @(posedge clk) begin
        clr_bits = 2'b00;
        case (avm_address)
            2'd2:    avm_readdata <= {30'd0, pio_mask};
            2'd3:    avm_readdata <= {30'd0, edge_cap};
            default: avm_readdata <= 32'd0;
        endcase
        if (avm_chipselect && !avm_write_n) begin
            if (avm_address == 2'd2) pio_mask <= avm_writedata[1:0];
            if (avm_address == 2'd3) clr_bits = avm_writedata[1:0];
            if (ev_n < 64) begin
                ev_kind[ev_n] <= 0;
                ev_addr[ev_n] <= avm_address;
                ev_data[ev_n] <= avm_writedata;
            end
            ev_n <= ev_n + 1;
        end else if (avm_address == 2'd3 && !avm_chipselect && !rd_prev) begin
            if (ev_n < 64) begin
                ev_kind[ev_n] <= 1;
                ev_addr[ev_n] <= avm_address;
                ev_data[ev_n] <= 32'd0;
            end
            ev_n <= ev_n + 1;
        end
        rd_prev  <= (avm_address == 2'd3) && !avm_chipselect;
        edge_cap <= (edge_cap & ~clr_bits) | inj;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (evt_valid !== 1'b1 && n < lim) begin
            step();
            n++;
        end
    endtask

    initial begin
        int   n;
        int   mark;
        logic seen;

        reset_n     = 1'b0;
        en          = 1'b1;
        cfg_mask    = 2'b00;
        cfg_mask_wr = 1'b0;
        evt_ready   = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_valid",   32'(evt_valid), 32'd0);
        chk("rst_buttons", 32'(evt_buttons), 32'd0);
        chk("rst_count",   32'(evt_count), 32'd0);
        chk("rst_cs",      32'(avm_chipselect), 32'd0);
        chk("rst_wn",      32'(avm_write_n), 32'd1);
        chk("rst_addr",    32'(avm_address), 32'd0);
        chk("rst_wdata",   avm_writedata, 32'd0);
        chk("rst_busy",    32'(busy), 32'd1);

        // First active cycle: irq_mask write of 3.
        step();
        chk("init_cs",    32'(avm_chipselect), 32'd1);
        chk("init_wn",    32'(avm_write_n), 32'd0);
        chk("init_addr",  32'(avm_address), 32'd2);
        chk("init_wdata", avm_writedata, 32'd3);
        chk("init_busy",  32'(busy), 32'd0);
        step();
        chk("init_cs_drop", 32'(avm_chipselect), 32'd0);
        chk("init_mask",    32'(pio_mask), 32'd3);

        // Basic service of button 0 with a ready consumer.
        mark = ev_n;
        inj  = 2'b01;
        step();
        inj  = 2'b00;
        chk("irq_up", 32'(irq), 32'd1);
        wait_valid(20, n);
        chk("latency",      32'(n), 32'd5);
        chk("evt_btn_01",   32'(evt_buttons), 32'd1);
        chk("log_rd_kind",  32'(ev_kind[mark]), 32'd1);
        chk("log_rd_addr",  32'(ev_addr[mark]), 32'd3);
        chk("log_clr_kind", 32'(ev_kind[mark+1]), 32'd0);
        chk("log_clr_addr", 32'(ev_addr[mark+1]), 32'd3);
        chk("log_clr_data", ev_data[mark+1], 32'hFFFF_FFFF);
        chk("edge_cleared", 32'(edge_cap), 32'd0);
        step();
        chk("hs_valid_drop", 32'(evt_valid), 32'd0);
        chk("hs_count_1",    32'(evt_count), 32'd1);

        // New edge during hold-off: not read until 8 hold-off cycles pass.
        inj       = 2'b10;
        evt_ready = 1'b0;
        step();
        inj = 2'b00;
        n   = 1;
        while (!(avm_address == 2'd3 && !avm_chipselect) && n < 30) begin
            step();
            n++;
        end
        chk("holdoff_len", 32'(n), 32'd9);
        wait_valid(20, n);
        chk("stall_latency", 32'(n), 32'd4);
        chk("stall_btn",     32'(evt_buttons), 32'd2);

        // Stalled consumer; two mask requests (last one wins) plus a new edge.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stall_hold", {13'd0, evt_valid, evt_buttons, evt_count}, {13'd0, 1'b1, 2'b10, 16'd1});
            if (i == 3) begin
                cfg_mask    = 2'b01;
                cfg_mask_wr = 1'b1;
            end else if (i == 5) begin
                cfg_mask    = 2'b10;
                cfg_mask_wr = 1'b1;
                inj         = 2'b10;
            end else begin
                cfg_mask_wr = 1'b0;
                inj         = 2'b00;
            end
        end
        mark      = ev_n;
        evt_ready = 1'b1;
        step();
        chk("hs2_valid", 32'(evt_valid), 32'd0);
        chk("hs2_count", 32'(evt_count), 32'd2);
        n = 0;
        while (!(avm_address == 2'd3 && !avm_chipselect) && n < 30) begin
            step();
            n++;
        end
        chk("mask_then_rd_n",  32'(ev_n - mark), 32'd1);
        chk("mask_wr_kind",    32'(ev_kind[mark]), 32'd0);
        chk("mask_wr_addr",    32'(ev_addr[mark]), 32'd2);
        chk("mask_wr_data",    ev_data[mark], 32'd2);
        chk("pio_mask_2",      32'(pio_mask), 32'd2);
        wait_valid(20, n);
        chk("svc3_btn",        32'(evt_buttons), 32'd2);
        chk("svc3_rd_kind",    32'(ev_kind[mark+1]), 32'd1);
        step();
        chk("hs3_count",       32'(evt_count), 32'd3);

        // Spurious irq: read and clear, no event.
        n = 0;
        while (busy && n < 30) begin
            step();
            n++;
        end
        chk("idle_before_spur", 32'(busy), 32'd0);
        mark      = ev_n;
        force_irq = 1'b1;
        step();
        force_irq = 1'b0;
        seen      = 1'b0;
        repeat (12) begin
            step();
            if (evt_valid !== 1'b0) seen = 1'b1;
        end
        chk("spur_no_valid", 32'(seen), 32'd0);
        chk("spur_count",    32'(evt_count), 32'd3);
        chk("spur_busy",     32'(busy), 32'd0);
        chk("spur_log_n",    32'(ev_n - mark), 32'd2);
        chk("spur_rd",       32'(ev_kind[mark]), 32'd1);
        chk("spur_clr_addr", 32'(ev_addr[mark+1]), 32'd3);
        chk("spur_clr_data", ev_data[mark+1], 32'hFFFF_FFFF);

        // Reset while an event is waiting.
        evt_ready = 1'b0;
        inj       = 2'b10;
        step();
        inj = 2'b00;
        wait_valid(20, n);
        chk("pre_rst_valid", 32'(evt_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid",   32'(evt_valid), 32'd0);
        chk("arst_buttons", 32'(evt_buttons), 32'd0);
        chk("arst_count",   32'(evt_count), 32'd0);
        chk("arst_busy",    32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("reinit_cs",    32'(avm_chipselect), 32'd1);
        chk("reinit_wn",    32'(avm_write_n), 32'd0);
        chk("reinit_addr",  32'(avm_address), 32'd2);
        chk("reinit_wdata", avm_writedata, 32'd3);
        step();
        chk("reinit_mask",  32'(pio_mask), 32'd3);
        chk("reinit_count", 32'(evt_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_irq_servicer.md
Name: btn_irq_servicer

Overview:
Hardware interrupt servicer for the 2-bit push-button PIO (Avalon-MM slave with data/irq_mask/edge_capture registers at word addresses 0/2/3). It acts as the PIO's only Avalon-MM master. After reset it programs the interrupt mask. On irq it reads edge_capture, clears it, and hands the captured button set downstream as a valid/ready event. A hold-off timer follows each event for debounce, so the LED logic needs no CPU involvement.

Parameters:
N_BTN, 2, button count; width of mask, capture and event fields.
MASK_INIT, 2'b11, irq_mask value written after reset.
HOLDOFF_CYCLES, 50000, idle cycles after each event before irq is re-sampled (1 ms at 50 MHz); 0 means no hold-off.
CNT_W, 16, width of the event counter.

Ports:
clk  in  1  system clock
reset_n  in  1  reset
en  in  1  service enable; low parks the FSM in IDLE after the current service completes
cfg_mask  in  N_BTN  new irq_mask value
cfg_mask_wr  in  1  1-cycle pulse: request a mask rewrite with cfg_mask
irq  in  1  PIO interrupt
avm_address  out  2  PIO word address
avm_chipselect  out  1  PIO select
avm_write_n  out  1  PIO write strobe, active low
avm_writedata  out  32  PIO write data
avm_readdata  in  32  PIO read data; registered in the PIO, valid 1 cycle after the address is presented
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts the event
evt_buttons  out  N_BTN  captured falling-edge set; nonzero when valid
evt_count  out  CNT_W  events accepted since reset, wrapping
busy  out  1  high in every state except IDLE

Behaviour:
- One clock. Reset is asynchronous and active-low: clk, reset_n.
- Reset values: FSM=INIT_MASK, avm_address=0, avm_chipselect=0, avm_write_n=1, avm_writedata=0, evt_valid=0, evt_buttons=0, evt_count=0, mask_pend=0, holdoff counter=0.
- All Avalon outputs are registered. avm_chipselect is high only for single-cycle writes. Reads need only the address, because the PIO samples the address every cycle.
- States:
  - INIT_MASK: one write cycle with address=2 and writedata={0,MASK_INIT}. Then IDLE.
  - IDLE:
    - If mask_pend: go to WR_MASK (takes priority over irq).
    - Else if en and irq: go to RD_ADDR.
  - WR_MASK: one write cycle with address=2 and writedata={0,cfg_mask_latched}. Clear mask_pend. Then IDLE.
  - RD_ADDR: drive address=3, chipselect=0. Then RD_WAIT.
  - RD_WAIT: address held at 3. Then RD_CAP.
  - RD_CAP: latch cap=avm_readdata[N_BTN-1:0]. Then CLR.
  - CLR: one write cycle with address=3 and writedata=32'hFFFF_FFFF. Clears all capture bits.
    - If cap==0 (spurious irq): go to IDLE, no event.
    - Else: go to EMIT.
  - EMIT:
    - evt_valid=1 and evt_buttons=cap, held stable until evt_ready.
    - On the cycle where evt_valid and evt_ready are both high: evt_count += 1 (wraps), evt_valid drops the next cycle, then HOLDOFF.
  - HOLDOFF: count up to HOLDOFF_CYCLES, then IDLE. Skipped when the parameter is 0.
- cfg_mask_wr in any state:
  - Latches cfg_mask and sets mask_pend.
  - A later pulse before servicing overwrites the latched value; last pulse wins.
  - Pulses during INIT_MASK are honoured afterwards.
- Latency: irq high in IDLE → evt_valid high 5 cycles later, with a ready consumer.
- Edges captured by the PIO after RD_CAP and before the CLR write completes are lost. This window is 1 cycle and is accepted.
  - Edges after CLR re-assert irq. They are serviced once HOLDOFF ends.
- irq deasserting mid-service does not abort the sequence.
- en dropping mid-service does not abort; the FSM stops at IDLE.
- Reset mid-operation: all state returns to reset values and INIT_MASK re-runs. A pending event is discarded.
- Avalon master remains the sole PIO accessor; no wait-request support (PIO has none).

Decomposition:
- Shared package:
  - PIO register address constants: ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
  - FSM state enum.
  - CLR_ALL=32'hFFFF_FFFF.
- Sub-module btn_holdoff_timer: load/count/done down-counter, parameterised by HOLDOFF_CYCLES.
- All else stays in one module.

Test Plan:
- Reset release → a write to address 2 with data 3 on the first active cycle; FSM reaches IDLE; busy=0.
- PIO model with edge_capture=2'b01 raises irq, evt_ready=1 → read at address 3, write address 3 with FFFFFFFF, evt_buttons=01 with valid 5 cycles after irq, evt_count=1, no re-service for HOLDOFF_CYCLES (set to 8 on the bench).
- evt_ready held low for 20 cycles with cap=2'b10 → evt_valid and evt_buttons=10 stable for all 20 cycles; evt_count increments only on the handshake cycle.
- cfg_mask_wr with 2'b10 pulsed during EMIT and irq high afterwards → after HOLDOFF the address-2 write with data 2 is issued before the next address-3 read.
- Spurious irq with edge_capture=0 → read and clear happen, evt_valid stays 0, evt_count unchanged.
- reset_n asserted during EMIT → evt_valid drops at once (asynchronously); after release INIT_MASK re-writes 3 and evt_count=0.
